// File: rtl/coin_acceptor_pkg.sv
// Shared definitions for the coin acceptor: FSM state encoding, channel codes
// and the default debounce length.
package coin_acceptor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EMIT    = 2'd1,
    ST_REJECT  = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CH_NONE = 2'd0,
    CH_C100 = 2'd1,
    CH_C200 = 2'd2,
    CH_C500 = 2'd3
  } chan_e;

  localparam logic [7:0] DEBOUNCE_DEFAULT = 8'd4;

endpackage

// File: rtl/coin_acceptor_debounce_channel.sv
// One coin-sensor channel: 2-flop synchroniser followed by a saturating
// debounce counter; stable_o is high while the counter sits at DEBOUNCE.
module debounce_channel
  import coin_acceptor_pkg::*;
#(
  parameter logic [7:0] DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic sync_o,
  output logic stable_o
);

  logic       meta_q;
  logic       sync_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      cnt_q  <= 8'd0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      cnt_q  <= cnt_d;
    end
  end

  // Any low sample restarts the count, so a bouncing edge must hold clean.
  always_comb begin
    cnt_d = cnt_q;
    if (!sync_q) begin
      cnt_d = 8'd0;
    end else if (cnt_q < DEBOUNCE) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign sync_o   = sync_q;
  assign stable_o = (cnt_q == DEBOUNCE);

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: three debounced sensor channels feed an accept/reject FSM that
// emits one registered pulse per coin and keeps a wrapping accepted-coin count.
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter logic [7:0] DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       raw100_i,
  input  logic       raw200_i,
  input  logic       raw500_i,
  input  logic       busy_i,
  output logic       in100_o,
  output logic       in200_o,
  output logic       in500_o,
  output logic       reject_o,
  output logic [7:0] accepted_count_o,
  output logic [1:0] state_o
);

  logic [2:0] sync;
  logic [2:0] stable;
  logic [2:0] raw;

  assign raw = {raw500_i, raw200_i, raw100_i};

  for (genvar g = 0; g < 3; g++) begin : g_chan
    debounce_channel #(.DEBOUNCE(DEBOUNCE)) u_chan (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .raw_i   (raw[g]),
      .sync_o  (sync[g]),
      .stable_o(stable[g])
    );
  end

  state_e     state_q, state_d;
  chan_e      chan_q, chan_d;
  logic [1:0] n_stable;
  logic       in100_q, in200_q, in500_q, reject_q;
  logic [7:0] count_q;

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    n_stable = {1'b0, stable[0]} + {1'b0, stable[1]} + {1'b0, stable[2]};
    unique case (state_q)
      ST_IDLE: begin
        // busy only matters here; later states run to completion regardless.
        if (n_stable >= 2'd2 || (n_stable == 2'd1 && busy_i)) begin
          state_d = ST_REJECT;
        end else if (n_stable == 2'd1) begin
          state_d = ST_EMIT;
          chan_d  = stable[0] ? CH_C100 : (stable[1] ? CH_C200 : CH_C500);
        end
      end
      ST_EMIT:    state_d = ST_RELEASE;
      ST_REJECT:  state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (sync == 3'b000) state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Pulses are registered from the next state so they coincide with EMIT/REJECT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      chan_q   <= CH_NONE;
      in100_q  <= 1'b0;
      in200_q  <= 1'b0;
      in500_q  <= 1'b0;
      reject_q <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      in100_q  <= (state_d == ST_EMIT) && (chan_d == CH_C100);
      in200_q  <= (state_d == ST_EMIT) && (chan_d == CH_C200);
      in500_q  <= (state_d == ST_EMIT) && (chan_d == CH_C500);
      reject_q <= (state_d == ST_REJECT);
      if (state_q == ST_EMIT) count_q <= count_q + 8'd1;
    end
  end

  assign in100_o          = in100_q;
  assign in200_o          = in200_q;
  assign in500_o          = in500_q;
  assign reject_o         = reject_q;
  assign accepted_count_o = count_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Testbench for coin_acceptor: directed scenarios plus randomized coin traffic,
// every cycle compared against a slot-level behavioural model.
module tb_coin_acceptor;
  import coin_acceptor_pkg::*;

  localparam int D = 4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [2:0] raw   = 3'b000;
  logic       busy  = 1'b0;
  logic       in100_o, in200_o, in500_o, reject_o;
  logic [7:0] accepted_count_o;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  coin_acceptor #(.DEBOUNCE(8'd4)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .raw100_i        (raw[0]),
    .raw200_i        (raw[1]),
    .raw500_i        (raw[2]),
    .busy_i          (busy),
    .in100_o         (in100_o),
    .in200_o         (in200_o),
    .in500_o         (in500_o),
    .reject_o        (reject_o),
    .accepted_count_o(accepted_count_o),
    .state_o         (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // The slot is "locked" from the accept/refuse decision until the sensors are
  // seen empty again; m_out is {reject, in500, in200, in100}.
  logic [2:0] m_s1 = '0, m_s2 = '0;
  int         m_run [3] = '{0, 0, 0};
  logic       m_locked = 1'b0;
  logic [3:0] m_out = '0;
  logic [7:0] m_cnt = '0;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_s1 = '0; m_s2 = '0; m_locked = 1'b0; m_out = '0; m_cnt = '0;
      for (int c = 0; c < 3; c++) m_run[c] = 0;
    end else begin
      logic [2:0] st;
      logic [2:0] syn;
      logic [3:0] prev;
      int         n;
      syn  = m_s2;
      prev = m_out;
      n    = 0;
      for (int c = 0; c < 3; c++) begin
        st[c] = (m_run[c] == D);
        n += int'(st[c]);
      end
      m_out = '0;
      if (!m_locked) begin
        if (n >= 2 || (n == 1 && busy)) begin
          m_out = 4'b1000; m_locked = 1'b1;
        end else if (n == 1) begin
          m_out = {1'b0, st}; m_locked = 1'b1;
        end
      end else if (prev == 4'b0000 && syn == 3'b000) begin
        m_locked = 1'b0;
      end
      if (prev[2:0] != 3'b000) m_cnt = m_cnt + 8'd1;
      for (int c = 0; c < 3; c++)
        m_run[c] = syn[c] ? ((m_run[c] < D) ? m_run[c] + 1 : D) : 0;
      m_s2 = m_s1;
      m_s1 = raw;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int t_in [3] = '{0, 0, 0};
  int t_rej = 0;

  always @(negedge clk_i) begin
    check("in100", 32'(in100_o), 32'(m_out[0]));
    check("in200", 32'(in200_o), 32'(m_out[1]));
    check("in500", 32'(in500_o), 32'(m_out[2]));
    check("reject", 32'(reject_o), 32'(m_out[3]));
    check("count", 32'(accepted_count_o), 32'(m_cnt));
    check("onehot", 32'($countones({reject_o, in500_o, in200_o, in100_o}) <= 1), 32'd1);
    if (!rst_i) begin
      t_in[0] += int'(in100_o);
      t_in[1] += int'(in200_o);
      t_in[2] += int'(in500_o);
      t_rej   += int'(reject_o);
    end
  end

  // ---------------- driver tasks ----------------
  int b_in [3];
  int b_rej;

  task automatic snap();
    for (int c = 0; c < 3; c++) b_in[c] = t_in[c];
    b_rej = t_rej;
  endtask

  task automatic expect_delta(input string tag, input int e100, input int e200,
                              input int e500, input int erej);
    check({tag, "_n100"}, 32'(t_in[0] - b_in[0]), 32'(e100));
    check({tag, "_n200"}, 32'(t_in[1] - b_in[1]), 32'(e200));
    check({tag, "_n500"}, 32'(t_in[2] - b_in[2]), 32'(e500));
    check({tag, "_nrej"}, 32'(t_rej - b_rej), 32'(erej));
  endtask

  task automatic coin(input logic [2:0] mask, input int hold, input logic bz);
    @(negedge clk_i);
    raw  = mask;
    busy = bz;
    repeat (hold) @(negedge clk_i);
    raw  = 3'b000;
    busy = 1'b0;
    repeat (6) @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #1 rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [19:0] pat;
    int          lat;
    logic        found;
    logic [2:0]  mask;
    int          hold;

    repeat (3) @(negedge clk_i);
    check("rst_state", 32'(state_o), 32'(ST_IDLE));
    check("rst_count", 32'(accepted_count_o), 32'd0);
    #1 rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Bouncy 200 coin: three drop-outs early, then a long clean hold.
    snap();
    pat = 20'b1111_1111_1111_1101_0101;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      raw[1] = pat[i];
    end
    @(negedge clk_i); raw = 3'b000;
    repeat (8) @(negedge clk_i);
    expect_delta("bounce", 0, 1, 0, 0);
    check("bounce_count", 32'(accepted_count_o), 32'd1);

    // Clean edge latency: 2 sync + DEBOUNCE + 1 edges.
    @(negedge clk_i); raw = 3'b001;
    lat = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_i);
      lat++;
      if (in100_o) found = 1'b1;
    end
    check("latency", 32'(lat), 32'(2 + D + 1));
    repeat (3) @(negedge clk_i);
    raw = 3'b000;
    repeat (6) @(negedge clk_i);
    check("latency_count", 32'(accepted_count_o), 32'd2);

    // Glitch shorter than DEBOUNCE.
    snap();
    coin(3'b100, 3, 1'b0);
    expect_delta("short", 0, 0, 0, 0);
    check("short_count", 32'(accepted_count_o), 32'd2);

    // Two coins at once.
    snap();
    coin(3'b101, 10, 1'b0);
    expect_delta("double", 0, 0, 0, 1);
    check("double_count", 32'(accepted_count_o), 32'd2);

    // Busy downstream refuses, then accepts once free.
    snap();
    coin(3'b001, 10, 1'b1);
    expect_delta("busy", 0, 0, 0, 1);
    snap();
    coin(3'b001, 10, 1'b0);
    expect_delta("free", 1, 0, 0, 0);
    check("free_count", 32'(accepted_count_o), 32'd3);

    // Reset on the edge that would enter EMIT, then re-debounce from zero.
    @(negedge clk_i); raw = 3'b010;
    repeat (6) @(negedge clk_i);
    snap();
    #1 rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    expect_delta("rst_emit", 0, 0, 0, 0);
    check("rst_emit_count", 32'(accepted_count_o), 32'd0);
    #1 rst_i = 1'b0;
    lat = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_i);
      lat++;
      if (in200_o) found = 1'b1;
    end
    check("rst_relatency", 32'(lat), 32'(2 + D + 1));
    raw = 3'b000;
    repeat (6) @(negedge clk_i);

    // Count wrap: 255 coins then one more.
    do_reset();
    for (int k = 0; k < 255; k++) begin
      mask = 3'b001 << $urandom_range(0, 2);
      coin(mask, 7, 1'b0);
    end
    check("count_255", 32'(accepted_count_o), 32'd255);
    coin(3'b100, 7, 1'b0);
    check("count_wrap", 32'(accepted_count_o), 32'd0);

    // Randomized traffic with bounces and busy toggling.
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 4) != 0) mask = 3'b001 << $urandom_range(0, 2);
      else mask = 3'($urandom_range(1, 7));
      hold = $urandom_range(1, 12);
      for (int j = 0; j < hold; j++) begin
        @(negedge clk_i);
        raw  = (j < 3 && $urandom_range(0, 1) == 1) ? 3'b000 : mask;
        busy = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk_i);
      raw  = 3'b000;
      busy = ($urandom_range(0, 1) == 1);
      repeat ($urandom_range(3, 8)) @(negedge clk_i);
    end
    busy = 1'b0;
    repeat (8) @(negedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
